// File: rtl/uut_test_pkg.sv
// Shared types and constants for the UUT test sequencer.
package uut_test_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    UUT_RST = 4'd1,
    RUN     = 4'd2,
    CHECK   = 4'd3,
    REPORT  = 4'd4
  } state_t;

  localparam int unsigned DBG_OUT  = 0;
  localparam int unsigned DBG_CYC  = 1;
  localparam int unsigned DBG_STAT = 2;
  localparam int unsigned DBG_IN   = 3;

endpackage

// File: rtl/uut_run_timer.sv
// Saturating run-cycle counter; count holds the number of completed RUN cycles,
// expired flags that the current cycle is cycle number TIMEOUT.
module uut_run_timer #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  // Stops at TIMEOUT-1 so count+1 never exceeds TIMEOUT and never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/uut_test_sequencer.sv
// Drives one UUT per test vector: reset pulse, timed run, optional repeat runs
// for determinism checking, then a held result for the writer.
module uut_test_sequencer
  import uut_test_pkg::*;
#(
  parameter int          IN_W       = 128,
  parameter int          OUT_W      = 128,
  parameter int          CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned REPEAT     = 1,
  parameter int          SEL_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_data,
  output logic             rst_uut,
  output logic [IN_W-1:0]  input_to_uut,
  input  logic             end_uut,
  input  logic [OUT_W-1:0] output_from_uut,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic [CNT_W-1:0] res_cycles,
  output logic             res_timeout,
  output logic             res_mismatch,
  input  logic [SEL_W-1:0] sw_debug,
  output logic [31:0]      debug
);

  state_t           state, next_state;
  logic [31:0]      rst_cnt;
  logic [31:0]      run_cnt;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_expired;
  logic [OUT_W-1:0] rec_out;
  logic [CNT_W-1:0] rec_cyc;
  logic             more_runs;
  logic [31:0]      cyc32;

  // Timer is held clear outside RUN, so it starts from zero on every run.
  uut_run_timer #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != RUN),
    .en     (state == RUN),
    .count  (tmr_count),
    .expired(tmr_expired)
  );

  assign more_runs = (run_cnt < 32'(REPEAT - 1));
  assign vec_ready = (state == IDLE);
  assign rst_uut   = (state != RUN);
  assign res_valid = (state == REPORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (vec_valid) next_state = UUT_RST;
      UUT_RST: if (rst_cnt == 32'(RST_CYCLES - 1)) next_state = RUN;
      RUN:     if (end_uut || tmr_expired) next_state = CHECK;
      CHECK:   next_state = more_runs ? UUT_RST : REPORT;
      REPORT:  if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A run ending on its TIMEOUT-th cycle with end_uut high is a success.
  always_ff @(posedge clk) begin
    if (rst) begin
      input_to_uut <= '0;
      res_data     <= '0;
      res_cycles   <= '0;
      res_timeout  <= 1'b0;
      res_mismatch <= 1'b0;
      rec_out      <= '0;
      rec_cyc      <= '0;
      run_cnt      <= '0;
      rst_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (vec_valid) begin
            input_to_uut <= vec_data;
            res_timeout  <= 1'b0;
            res_mismatch <= 1'b0;
            run_cnt      <= '0;
            rst_cnt      <= '0;
          end
        end
        UUT_RST: begin
          rst_cnt <= rst_cnt + 32'd1;
        end
        RUN: begin
          if (end_uut || tmr_expired) begin
            rec_out <= output_from_uut;
            rec_cyc <= tmr_count + CNT_W'(1);
            if (!end_uut) res_timeout <= 1'b1;
          end
        end
        CHECK: begin
          if (run_cnt == 32'd0) begin
            res_data   <= rec_out;
            res_cycles <= rec_cyc;
          end else if (rec_out != res_data) begin
            res_mismatch <= 1'b1;
          end
          if (more_runs) begin
            run_cnt <= run_cnt + 32'd1;
            rst_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  if (CNT_W >= 32) begin : g_cyc_trunc
    assign cyc32 = res_cycles[31:0];
  end else begin : g_cyc_ext
    assign cyc32 = {{(32 - CNT_W){1'b0}}, res_cycles};
  end

  always_comb begin
    debug = 32'd0;
    case (32'(sw_debug))
      DBG_OUT:  debug = res_data[31:0];
      DBG_CYC:  debug = cyc32;
      DBG_STAT: debug = {state, run_cnt[11:0], 14'd0, res_mismatch, res_timeout};
      DBG_IN:   debug = input_to_uut[31:0];
      default:  debug = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uut_test_sequencer.sv
// Directed bench: instance a (REPEAT=1, TIMEOUT=100) and instance b (REPEAT=3),
// each paired with a behavioural UUT model.
module tb_uut_test_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         vec_valid_a, vec_ready_a, rst_uut_a, end_uut_a, res_valid_a, res_ready_a;
  logic [127:0] vec_data_a, input_to_uut_a, out_a, res_data_a;
  logic [31:0]  res_cycles_a, debug_a;
  logic         res_timeout_a, res_mismatch_a;
  logic [1:0]   sw_debug_a;

  logic         vec_valid_b, vec_ready_b, rst_uut_b, end_uut_b, res_valid_b, res_ready_b;
  logic [127:0] vec_data_b, input_to_uut_b, out_b, res_data_b;
  logic [31:0]  res_cycles_b, debug_b;
  logic         res_timeout_b, res_mismatch_b;
  logic [1:0]   sw_debug_b;

  uut_test_sequencer #(.IN_W(128), .OUT_W(128), .CNT_W(32), .TIMEOUT(100),
                       .RST_CYCLES(4), .REPEAT(1), .SEL_W(2)) dut_a (
    .clk(clk), .rst(rst), .vec_valid(vec_valid_a), .vec_ready(vec_ready_a),
    .vec_data(vec_data_a), .rst_uut(rst_uut_a), .input_to_uut(input_to_uut_a),
    .end_uut(end_uut_a), .output_from_uut(out_a), .res_valid(res_valid_a),
    .res_ready(res_ready_a), .res_data(res_data_a), .res_cycles(res_cycles_a),
    .res_timeout(res_timeout_a), .res_mismatch(res_mismatch_a),
    .sw_debug(sw_debug_a), .debug(debug_a));

  uut_test_sequencer #(.IN_W(128), .OUT_W(128), .CNT_W(32), .TIMEOUT(100),
                       .RST_CYCLES(4), .REPEAT(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .vec_valid(vec_valid_b), .vec_ready(vec_ready_b),
    .vec_data(vec_data_b), .rst_uut(rst_uut_b), .input_to_uut(input_to_uut_b),
    .end_uut(end_uut_b), .output_from_uut(out_b), .res_valid(res_valid_b),
    .res_ready(res_ready_b), .res_data(res_data_b), .res_cycles(res_cycles_b),
    .res_timeout(res_timeout_b), .res_mismatch(res_mismatch_b),
    .sw_debug(sw_debug_b), .debug(debug_b));

  // UUT model a: end_uut rises on the n_a-th cycle after rst_uut falls.
  int   mcnt_a, n_a, low_a;
  logic en_a, force_end_a;
  always_ff @(posedge clk) begin
    mcnt_a <= rst_uut_a ? 0 : mcnt_a + 1;
    if (!rst_uut_a) low_a <= low_a + 1;
  end
  assign end_uut_a = force_end_a | (!rst_uut_a && en_a && (mcnt_a >= n_a - 1));

  // UUT model b: done after 5 cycles; third run optionally flips bit 0.
  localparam logic [127:0] A_OUT = 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0;
  int   mcnt_b, pulses_b;
  logic last_b, flip_b;
  always_ff @(posedge clk) begin
    mcnt_b <= rst_uut_b ? 0 : mcnt_b + 1;
    last_b <= rst_uut_b;
    if (last_b && !rst_uut_b) pulses_b <= pulses_b + 1;
  end
  assign end_uut_b = !rst_uut_b && (mcnt_b >= 4);
  assign out_b     = (flip_b && pulses_b % 3 == 0) ? (A_OUT ^ 128'd1) : A_OUT;

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(input bit sel, inout int lat);
    while (lat < 2000 && !(sel ? res_valid_b : res_valid_a)) begin
      tick();
      lat++;
    end
    check_output("result_arrives", 128'(lat < 2000), 128'd1);
  endtask

  task automatic apply_stimulus(input bit sel, input logic [127:0] v, output int lat);
    if (sel) begin vec_data_b = v; vec_valid_b = 1'b1; end
    else     begin vec_data_a = v; vec_valid_a = 1'b1; end
    tick();
    lat = 1;
    vec_valid_a = 1'b0;
    vec_valid_b = 1'b0;
    wait_result(sel, lat);
  endtask

  task automatic handshake(input bit sel);
    if (sel) res_ready_b = 1'b1; else res_ready_a = 1'b1;
    tick();
    res_ready_a = 1'b0;
    res_ready_b = 1'b0;
  endtask

  localparam logic [127:0] VEC1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] OUT1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] OUT2 = 128'h0BAD_CAFE_0000_0000_0000_0000_1357_9BDF;

  initial begin
    int  lat, l0, p0;
    bit  ok;
    logic [127:0] held;
    rst = 1'b1;
    vec_valid_a = 0; vec_data_a = '0; res_ready_a = 0; sw_debug_a = 2'd2;
    vec_valid_b = 0; vec_data_b = '0; res_ready_b = 0; sw_debug_b = 2'd2;
    en_a = 0; n_a = 1; force_end_a = 0; out_a = OUT1; flip_b = 0;
    mcnt_a = 0; low_a = 0; mcnt_b = 0; pulses_b = 0; last_b = 1;
    tick(); tick();
    check_output("rst_vec_ready", vec_ready_a, 1'b1);
    check_output("rst_rst_uut", rst_uut_a, 1'b1);
    check_output("rst_res_valid", res_valid_a, 1'b0);
    check_output("rst_res_data", res_data_a, '0);
    check_output("rst_stat", debug_a, 32'd0);
    rst = 1'b0;
    tick();

    // Basic run: 37-cycle UUT.
    en_a = 1; n_a = 37; l0 = low_a;
    apply_stimulus(0, VEC1, lat);
    check_output("basic_latency", lat, 43);
    check_output("basic_data", res_data_a, OUT1);
    check_output("basic_cycles", res_cycles_a, 37);
    check_output("basic_timeout", res_timeout_a, 1'b0);
    check_output("basic_mismatch", res_mismatch_a, 1'b0);
    check_output("basic_low_cycles", low_a - l0, 37);
    check_output("basic_dbg_stat", debug_a, 32'h4000_0000);
    sw_debug_a = 2'd0; #1;
    check_output("basic_dbg_out", debug_a, 32'h5555_BEEF);
    sw_debug_a = 2'd1; #1;
    check_output("basic_dbg_cyc", debug_a, 32'd37);
    sw_debug_a = 2'd3; #1;
    check_output("basic_dbg_in", debug_a, 32'h4455_6677);

    // Backpressure for 50 cycles.
    held = res_data_a; ok = 1;
    repeat (50) begin
      tick();
      if (res_valid_a !== 1'b1 || res_data_a !== held || res_cycles_a !== 32'd37 || vec_ready_a !== 1'b0)
        ok = 0;
    end
    check_output("bp_stable", ok, 1'b1);
    handshake(0);
    check_output("bp_valid_drop", res_valid_a, 1'b0);
    check_output("bp_vec_ready", vec_ready_a, 1'b1);

    // Back-to-back vector that never finishes: timeout.
    en_a = 0; out_a = OUT2; l0 = low_a;
    apply_stimulus(0, VEC1, lat);
    check_output("to_latency", lat, 106);
    check_output("to_flag", res_timeout_a, 1'b1);
    check_output("to_cycles", res_cycles_a, 100);
    check_output("to_data", res_data_a, OUT2);
    check_output("to_low_cycles", low_a - l0, 100);
    handshake(0);

    // end_uut on the very cycle count reaches TIMEOUT.
    en_a = 1; n_a = 100; out_a = OUT1;
    apply_stimulus(0, VEC1, lat);
    check_output("edge_timeout", res_timeout_a, 1'b0);
    check_output("edge_cycles", res_cycles_a, 100);
    handshake(0);

    // end_uut held during UUT reset must be ignored.
    n_a = 10; force_end_a = 1; vec_data_a = VEC1; vec_valid_a = 1;
    tick();
    vec_valid_a = 0; lat = 1;
    repeat (4) begin tick(); lat++; end
    force_end_a = 0;
    check_output("ign_in_run", rst_uut_a, 1'b0);
    wait_result(0, lat);
    check_output("ign_latency", lat, 16);
    check_output("ign_cycles", res_cycles_a, 10);
    handshake(0);

    // Repeat runs with a differing third output.
    flip_b = 1; p0 = pulses_b;
    apply_stimulus(1, VEC1, lat);
    check_output("rep_latency", lat, 31);
    check_output("rep_pulses", pulses_b - p0, 3);
    check_output("rep_data", res_data_b, A_OUT);
    check_output("rep_cycles", res_cycles_b, 5);
    check_output("rep_mismatch", res_mismatch_b, 1'b1);
    check_output("rep_dbg_stat", debug_b, 32'h4002_0002);
    handshake(1);
    flip_b = 0;
    apply_stimulus(1, VEC1, lat);
    check_output("rep_same_mismatch", res_mismatch_b, 1'b0);
    handshake(1);

    // Reset in the 20th RUN cycle.
    en_a = 0; vec_data_a = VEC1; vec_valid_a = 1;
    tick();
    vec_valid_a = 0;
    repeat (23) tick();
    check_output("mid_in_run", rst_uut_a, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mid_rst_uut", rst_uut_a, 1'b1);
    check_output("mid_vec_ready", vec_ready_a, 1'b1);
    check_output("mid_res_valid", res_valid_a, 1'b0);
    check_output("mid_input", input_to_uut_a, '0);
    sw_debug_a = 2'd1; #1;
    check_output("mid_dbg_cyc", debug_a, 32'd0);
    sw_debug_a = 2'd2; #1;
    check_output("mid_dbg_stat", debug_a, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
